// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths, the
// hardwired-zero register index and the source slot assignment.
package regfile_wb_arbiter_pkg;

    localparam int unsigned ADDR_W          = 5;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned NUM_SRC_DEFAULT = 3;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned SRC_ALU     = 0;
    localparam int unsigned SRC_MULTDIV = 1;
    localparam int unsigned SRC_LOAD    = 2;

    // Fold an index in 0..2n-2 back into 0..n-1 without a divider.
    function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant: first requester at or after the pointer, wrapping around.
// The pointer register is owned by the instantiating module.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    int unsigned w_cand;
    logic        w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            w_cand = wrap_idx(32'(i_ptr) + off, NUM_SRC);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Funnels NUM_SRC writeback requesters into the single register-file write port through
// 1-entry holding buffers, draining one per cycle round-robin while keeping per-register order.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_SRC = regfile_wb_arbiter_pkg::NUM_SRC_DEFAULT,
    parameter int unsigned DATA_W  = regfile_wb_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_reg,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    input  logic [ADDR_W-1:0]         query_reg,
    output logic                      query_hit
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] r_hold_valid;
    logic [ADDR_W-1:0]  r_hold_reg  [NUM_SRC];
    logic [DATA_W-1:0]  r_hold_data [NUM_SRC];
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_SRC-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any_grant;
    logic [NUM_SRC-1:0] w_waw_block;
    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_accept;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (r_hold_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx)
    );

    assign w_any_grant = |w_grant;

    // One outstanding write per register: block a source whose target is already held by
    // another (non-draining) entry, or is being accepted this cycle by a lower-index source.
    always_comb begin
        w_waw_block = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_reg[i*ADDR_W +: ADDR_W] != '0) begin
                for (int unsigned j = 0; j < NUM_SRC; j++) begin
                    if (j != i && r_hold_valid[j] && !w_grant[j] &&
                        r_hold_reg[j] == src_reg[i*ADDR_W +: ADDR_W]) begin
                        w_waw_block[i] = 1'b1;
                    end
                end
                for (int unsigned k = 0; k < i; k++) begin
                    if (src_valid[k] && !w_waw_block[k] && (!r_hold_valid[k] || w_grant[k]) &&
                        src_reg[k*ADDR_W +: ADDR_W] == src_reg[i*ADDR_W +: ADDR_W]) begin
                        w_waw_block[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_ready   = (~r_hold_valid | w_grant) & ~w_waw_block;
    assign w_accept  = src_valid & w_ready;
    assign src_ready = w_ready;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                r_hold_reg[i]  <= '0;
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                // r0 writes complete the handshake but never occupy the buffer.
                if (w_accept[i] && src_reg[i*ADDR_W +: ADDR_W] != '0) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_reg[i]   <= src_reg[i*ADDR_W +: ADDR_W];
                    r_hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
                end else if (w_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
            if (w_any_grant) begin
                r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_SRC - 1)) ? '0
                                                                  : w_grant_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        ctrl_writeEnable = w_any_grant;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                ctrl_writeReg = r_hold_reg[i];
                data_writeReg = r_hold_data[i];
            end
        end
    end

    always_comb begin
        query_hit = 1'b0;
        if (query_reg != '0) begin
            for (int unsigned j = 0; j < NUM_SRC; j++) begin
                if (r_hold_valid[j] && r_hold_reg[j] == query_reg) begin
                    query_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle-by-cycle vector table plus hand-written
// reset sequences, checking outputs at the falling edge.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = ADDR_W;
    localparam int unsigned DW = DATA_W;

    logic              clock;
    logic              ctrl_reset_n;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_ready;
    logic [N*AW-1:0]   src_reg;
    logic [N*DW-1:0]   src_data;
    logic              ctrl_writeEnable;
    logic [AW-1:0]     ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;
    logic [AW-1:0]     query_reg;
    logic              query_hit;

    regfile_wb_arbiter #(
        .NUM_SRC (N),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .src_reg          (src_reg),
        .src_data         (src_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .query_reg        (query_reg),
        .query_hit        (query_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] regs;
        logic [95:0] data;
        logic [4:0]  qreg;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        qhit;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [4:0] q, input logic [2:0] rdy,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic qh);
        vec_t t;
        t.valid = v;
        t.regs  = {r2, r1, r0};
        t.data  = {d2, d1, d0};
        t.qreg  = q;
        t.ready = rdy;
        t.we    = we;
        t.wreg  = wr;
        t.wdata = wd;
        t.qhit  = qh;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [4:0] q, input logic [2:0] rdy, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd, input logic qh);
        add(3'b000, REG_ZERO, REG_ZERO, REG_ZERO, 0, 0, 0, q, rdy, we, wr, wd, qh);
    endtask

    task automatic fill_table();
        // Post-reset: all three accepted together, drained 0,1,2.
        add(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 5'd1, 3'b111, 0, 0, 0, 0);
        idle(5'd2, 3'b001, 1, 5'd1, 32'h100, 1);
        idle(5'd1, 3'b011, 1, 5'd2, 32'h200, 0);
        idle(5'd3, 3'b111, 1, 5'd3, 32'h300, 1);
        idle(5'd3, 3'b111, 0, 5'd0, 32'h0, 0);
        // Single write from the ALU slot.
        add(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 5'd5, 3'b111, 0, 0, 0, 0);
        idle(5'd5, 3'b111, 1, 5'd5, 32'hDEADBEEF, 1);
        idle(5'd5, 3'b111, 0, 5'd0, 32'h0, 0);
        // Round-robin: pointer sits at 1, so contention drains 1,2,0.
        add(3'b001, 5'd1, 5'd0, 5'd0, 32'hA0, 0, 0, 5'd0, 3'b111, 0, 0, 0, 0);
        idle(5'd0, 3'b111, 1, 5'd1, 32'hA0, 0);
        add(3'b111, 5'd2, 5'd3, 5'd4, 32'hB0, 32'hB1, 32'hB2, 5'd4, 3'b111, 0, 0, 0, 0);
        idle(5'd4, 3'b010, 1, 5'd3, 32'hB1, 1);
        idle(5'd4, 3'b110, 1, 5'd4, 32'hB2, 1);
        idle(5'd4, 3'b111, 1, 5'd2, 32'hB0, 0);
        idle(5'd4, 3'b111, 0, 5'd0, 32'h0, 0);
        // r0 write from the mult/div slot is accepted and dropped.
        add(3'b010, 5'd0, REG_ZERO, 5'd0, 0, 32'h1234, 0, 5'd0, 3'b111, 0, 0, 0, 0);
        idle(5'd0, 3'b111, 0, 5'd0, 32'h0, 0);
        // WAW between same-cycle requesters: src2 waits for src0's commit.
        add(3'b101, 5'd7, 5'd0, 5'd7, 32'hAAAA, 0, 32'hBBBB, 5'd7, 3'b011, 0, 0, 0, 0);
        add(3'b100, 5'd0, 5'd0, 5'd7, 0, 0, 32'hBBBB, 5'd7, 3'b111, 1, 5'd7, 32'hAAAA, 1);
        idle(5'd7, 3'b111, 1, 5'd7, 32'hBBBB, 1);
        idle(5'd7, 3'b111, 0, 5'd0, 32'h0, 0);
        // WAW against an already-held entry that is not draining this cycle.
        add(3'b011, 5'd9, 5'd10, 5'd0, 32'hC0, 32'hC1, 0, 5'd10, 3'b111, 0, 0, 0, 0);
        add(3'b100, 5'd0, 5'd0, 5'd10, 0, 0, 32'hC2, 5'd10, 3'b001, 1, 5'd9, 32'hC0, 1);
        add(3'b100, 5'd0, 5'd0, 5'd10, 0, 0, 32'hC2, 5'd10, 3'b111, 1, 5'd10, 32'hC1, 1);
        idle(5'd10, 3'b111, 1, 5'd10, 32'hC2, 1);
        idle(5'd10, 3'b111, 0, 5'd0, 32'h0, 0);
        // Back-to-back writes from the load slot's neighbour (src0) at one per cycle.
        for (int k = 0; k < 8; k++) begin
            add(3'b001, 5'd12, 5'd0, 5'd0, 32'h50 + k, 0, 0, 5'd12, 3'b111, k > 0,
                (k > 0) ? 5'd12 : 5'd0, (k > 0) ? 32'h50 + k - 1 : 32'h0, k > 0);
        end
        idle(5'd12, 3'b111, 1, 5'd12, 32'h57, 1);
        idle(5'd12, 3'b111, 0, 5'd0, 32'h0, 0);
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] r, input logic [95:0] d,
                         input logic [4:0] q);
        src_valid = v;
        src_reg   = r;
        src_data  = d;
        query_reg = q;
    endtask

    initial begin
        fill_table();

        // Reset held with every source requesting.
        ctrl_reset_n = 1'b0;
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h300, 32'h200, 32'h100}, 5'd1);
        @(negedge clock);
        check("rst_we", 32'(ctrl_writeEnable), 0);
        check("rst_qhit", 32'(query_hit), 0);
        check("rst_ready", 32'(src_ready), 32'h7);
        @(negedge clock);
        check("rst_we_held", 32'(ctrl_writeEnable), 0);
        check("rst_wreg", 32'(ctrl_writeReg), 0);
        check("rst_wdata", data_writeReg, 0);
        @(posedge clock);
        #1 ctrl_reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].regs, vecs[i].data, vecs[i].qreg);
            @(negedge clock);
            check($sformatf("v%0d.ready", i), 32'(src_ready), 32'(vecs[i].ready));
            check($sformatf("v%0d.we", i), 32'(ctrl_writeEnable), 32'(vecs[i].we));
            check($sformatf("v%0d.wreg", i), 32'(ctrl_writeReg), 32'(vecs[i].wreg));
            check($sformatf("v%0d.wdata", i), data_writeReg, vecs[i].wdata);
            check($sformatf("v%0d.qhit", i), 32'(query_hit), 32'(vecs[i].qhit));
            @(posedge clock);
            #1;
        end

        // Reset while three entries are held: nothing may ever commit.
        drive(3'b111, {5'd22, 5'd21, 5'd20}, {32'hE2, 32'hE1, 32'hE0}, 5'd21);
        @(negedge clock);
        check("mid_accept_ready", 32'(src_ready), 32'h7);
        @(posedge clock);
        #1 drive(3'b000, '0, '0, 5'd21);
        @(negedge clock);
        check("mid_pre_we", 32'(ctrl_writeEnable), 1);
        check("mid_pre_qhit", 32'(query_hit), 1);
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("mid_async_we", 32'(ctrl_writeEnable), 0);
        check("mid_async_qhit", 32'(query_hit), 0);
        @(posedge clock);
        #1 ctrl_reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("mid_post%0d.we", c), 32'(ctrl_writeEnable), 0);
            check($sformatf("mid_post%0d.qhit", c), 32'(query_hit), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
